// File: rtl/elixirchip_es1_spu_op_mem_sdp_if.sv
// Request/response bundle for the ES1 SPU simple dual-port memory operator.
// master = op scheduler side, slave = memory operator side.
interface elixirchip_es1_spu_op_mem_sdp_if #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STRB_BITS = 1
);
  logic [ADDR_BITS-1:0] s_waddr;
  logic [DATA_BITS-1:0] s_wdata;
  logic [STRB_BITS-1:0] s_wstrb;
  logic                 s_wvalid;
  logic [ADDR_BITS-1:0] s_raddr;
  logic                 s_rvalid;
  logic [DATA_BITS-1:0] m_rdata;
  logic                 m_rvalid;

  modport master (
    output s_waddr, s_wdata, s_wstrb, s_wvalid, s_raddr, s_rvalid,
    input  m_rdata, m_rvalid
  );

  modport slave (
    input  s_waddr, s_wdata, s_wstrb, s_wvalid, s_raddr, s_rvalid,
    output m_rdata, m_rvalid
  );
endinterface

// File: rtl/elixirchip_es1_spu_op_mem_sdp.sv
// Simple dual-port memory operator: strobed write port, LATENCY-deep read pipeline,
// selectable read-during-write behaviour, everything qualified by cke.
module elixirchip_es1_spu_op_mem_sdp #(
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned ADDR_BITS  = 8,
  parameter int unsigned MEM_SIZE   = 2 ** ADDR_BITS,
  parameter int unsigned STRB_BITS  = 1,
  parameter string       RDW_MODE   = "read_first",
  parameter string       MEM_TYPE   = "block",
  parameter string       DEVICE     = "RTL",
  parameter string       SIMULATION = "false",
  parameter string       DEBUG      = "false"
) (
  input logic reset,
  input logic clk,
  input logic cke,
  elixirchip_es1_spu_op_mem_sdp_if.slave bus
);
  localparam int unsigned LANE_BITS   = DATA_BITS / STRB_BITS;
  localparam bit          WRITE_FIRST = (RDW_MODE == "write_first");

  if (LATENCY < 1 || MEM_SIZE > 2 ** ADDR_BITS || (DATA_BITS % STRB_BITS) != 0 ||
      !(RDW_MODE == "read_first" || RDW_MODE == "write_first") ||
      !(MEM_TYPE == "block" || MEM_TYPE == "distributed") || DEVICE == "" ||
      !(SIMULATION == "true" || SIMULATION == "false") ||
      !(DEBUG == "true" || DEBUG == "false")) begin : g_bad_cfg
    $error("elixirchip_es1_spu_op_mem_sdp: illegal parameter set");
  end

  logic [DATA_BITS-1:0] mem [MEM_SIZE];

  logic                 w_in_range;
  logic                 r_in_range;
  logic                 wr_en;
  logic [DATA_BITS-1:0] old_word;
  logic [DATA_BITS-1:0] merged;
  logic [DATA_BITS-1:0] rd_word;

  // Merged word serves both the strobed write and the write_first bypass.
  for (genvar l = 0; l < STRB_BITS; l++) begin : g_lane
    assign merged[l*LANE_BITS +: LANE_BITS] = bus.s_wstrb[l] ?
      bus.s_wdata[l*LANE_BITS +: LANE_BITS] : old_word[l*LANE_BITS +: LANE_BITS];
  end

  always_comb begin
    w_in_range = {1'b0, bus.s_waddr} < (ADDR_BITS + 1)'(MEM_SIZE);
    r_in_range = {1'b0, bus.s_raddr} < (ADDR_BITS + 1)'(MEM_SIZE);
    wr_en      = cke && bus.s_wvalid && w_in_range;
    old_word   = w_in_range ? mem[bus.s_waddr] : '0;
    rd_word    = '0;
    if (r_in_range) begin
      if (WRITE_FIRST && wr_en && bus.s_waddr == bus.s_raddr) rd_word = merged;
      else                                                    rd_word = mem[bus.s_raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[bus.s_waddr] <= merged;
  end

  // Stage data only advances with a valid beat, so bubbles leave the last value on m_rdata.
  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;

    if (g == 0) begin : g_head
      assign in_data  = rd_word;
      assign in_valid = bus.s_rvalid;
    end else begin : g_tail
      assign in_data  = g_stage[g-1].data;
      assign in_valid = g_stage[g-1].valid;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid <= 1'b0;
        data  <= '0;
      end else if (cke) begin
        valid <= in_valid;
        if (in_valid) data <= in_data;
      end
    end
  end

  assign bus.m_rdata  = g_stage[LATENCY-1].data;
  assign bus.m_rvalid = g_stage[LATENCY-1].valid;
endmodule

// File: tb/tb_elixirchip_es1_spu_op_mem_sdp.sv
// Bench: a read_first and a write_first instance share one stimulus stream and are
// compared every cycle against a memory + fixed-delay queue reference model.
module tb_elixirchip_es1_spu_op_mem_sdp;
  localparam int unsigned LAT = 3;
  localparam int unsigned MS  = 200;

  logic clk;
  logic reset;
  logic cke;
  logic [7:0]  waddr;
  logic [7:0]  raddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        rvalid;

  int checks;
  int failures;

  elixirchip_es1_spu_op_mem_sdp_if #(.ADDR_BITS(8), .DATA_BITS(32), .STRB_BITS(4)) rf_if ();
  elixirchip_es1_spu_op_mem_sdp_if #(.ADDR_BITS(8), .DATA_BITS(32), .STRB_BITS(4)) wf_if ();

  assign rf_if.s_waddr = waddr;  assign wf_if.s_waddr = waddr;
  assign rf_if.s_wdata = wdata;  assign wf_if.s_wdata = wdata;
  assign rf_if.s_wstrb = wstrb;  assign wf_if.s_wstrb = wstrb;
  assign rf_if.s_wvalid = wvalid; assign wf_if.s_wvalid = wvalid;
  assign rf_if.s_raddr = raddr;  assign wf_if.s_raddr = raddr;
  assign rf_if.s_rvalid = rvalid; assign wf_if.s_rvalid = rvalid;

  elixirchip_es1_spu_op_mem_sdp #(
    .LATENCY(LAT), .DATA_BITS(32), .ADDR_BITS(8), .MEM_SIZE(MS), .STRB_BITS(4),
    .RDW_MODE("read_first")
  ) u_rf (.reset(reset), .clk(clk), .cke(cke), .bus(rf_if));

  elixirchip_es1_spu_op_mem_sdp #(
    .LATENCY(LAT), .DATA_BITS(32), .ADDR_BITS(8), .MEM_SIZE(MS), .STRB_BITS(4),
    .RDW_MODE("write_first")
  ) u_wf (.reset(reset), .clk(clk), .cke(cke), .bus(wf_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  typedef struct packed { logic v; logic [31:0] d; } rd_t;
  logic [31:0] mdl_mem [MS];
  rd_t q_rf[$];
  rd_t q_wf[$];
  logic        exp_v_rf, exp_v_wf;
  logic [31:0] exp_d_rf, exp_d_wf;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (st[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  task automatic model_clear();
    q_rf.delete();
    q_wf.delete();
    exp_v_rf = 1'b0; exp_d_rf = '0;
    exp_v_wf = 1'b0; exp_d_wf = '0;
  endtask

  task automatic model_edge();
    rd_t e_rf, e_wf, o;
    logic [31:0] old;
    e_rf = '0; e_wf = '0;
    e_rf.v = rvalid; e_wf.v = rvalid;
    if (int'(raddr) < MS) begin
      old    = mdl_mem[raddr];
      e_rf.d = old;
      e_wf.d = (wvalid && waddr == raddr) ? merge(old, wdata, wstrb) : old;
    end
    q_rf.push_back(e_rf);
    q_wf.push_back(e_wf);
    if (wvalid && int'(waddr) < MS) mdl_mem[waddr] = merge(mdl_mem[waddr], wdata, wstrb);
    if (q_rf.size() == LAT) begin
      o = q_rf.pop_front(); exp_v_rf = o.v; if (o.v) exp_d_rf = o.d;
      o = q_wf.pop_front(); exp_v_wf = o.v; if (o.v) exp_d_wf = o.d;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (cke) model_edge();
    @(negedge clk);
    check_eq("rf_rvalid", 64'(rf_if.m_rvalid), 64'(exp_v_rf));
    check_eq("rf_rdata",  64'(rf_if.m_rdata),  64'(exp_d_rf));
    check_eq("wf_rvalid", 64'(wf_if.m_rvalid), 64'(exp_v_wf));
    check_eq("wf_rdata",  64'(wf_if.m_rdata),  64'(exp_d_wf));
  endtask

  task automatic idle();
    wvalid = 1'b0; rvalid = 1'b0; wstrb = '0; cke = 1'b1;
  endtask

  int stream_cnt;

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; cke = 1'b0;
    waddr = '0; raddr = '0; wdata = '0; wstrb = '0; wvalid = 1'b0; rvalid = 1'b0;
    for (int i = 0; i < MS; i++) mdl_mem[i] = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check_eq("reset_rvalid", 64'(rf_if.m_rvalid), 64'd0);
    check_eq("reset_rdata",  64'(rf_if.m_rdata),  64'd0);
    reset = 1'b0;
    idle();

    // Fill every word so the model and both arrays agree
    for (int i = 0; i < MS; i++) begin
      wvalid = 1'b1; waddr = 8'(i); wdata = $urandom; wstrb = 4'hF;
      step();
    end
    idle();

    // Partial strobe merge
    wvalid = 1'b1; waddr = 8'h02; wdata = 32'h11223344; wstrb = 4'hF; step();
    wdata = 32'hAABBCCDD; wstrb = 4'b0101; step();
    wvalid = 1'b0; rvalid = 1'b1; raddr = 8'h02; step();
    rvalid = 1'b0; step(); step();
    check_eq("strb_merge", 64'(rf_if.m_rdata), 64'h11BB33DD);

    // Read-during-write collision
    wvalid = 1'b1; waddr = 8'h04; wdata = 32'h33; wstrb = 4'hF; step();
    wdata = 32'h77; rvalid = 1'b1; raddr = 8'h04; step();
    wvalid = 1'b0; step();
    rvalid = 1'b0; step();
    check_eq("coll_read_first",  64'(rf_if.m_rdata), 64'h33);
    check_eq("coll_write_first", 64'(wf_if.m_rdata), 64'h77);
    step();
    check_eq("after_coll_rf", 64'(rf_if.m_rdata), 64'h77);
    check_eq("after_coll_wf", 64'(wf_if.m_rdata), 64'h77);

    // Streaming reads 0..7 at full rate
    repeat (LAT) step();
    stream_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      rvalid = (i < 8); raddr = 8'(i);
      step();
      if (rf_if.m_rvalid) stream_cnt++;
    end
    check_eq("stream_count", 64'(stream_cnt), 64'd8);
    idle();

    // cke stall with writes presented during the stall
    rvalid = 1'b1; raddr = 8'h09; step();
    rvalid = 1'b0; cke = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wvalid = 1'b1; waddr = 8'h09; wdata = $urandom; wstrb = 4'hF; rvalid = 1'b1;
      step();
    end
    idle(); step(); step();
    rvalid = 1'b1; raddr = 8'h09; step();
    idle(); repeat (LAT) step();

    // Out-of-range write and read
    wvalid = 1'b1; waddr = 8'd250; wdata = 32'hFF; wstrb = 4'hF; step();
    wvalid = 1'b0; rvalid = 1'b1; raddr = 8'd250; step();
    rvalid = 1'b0; step(); step();
    check_eq("oor_rdata",  64'(rf_if.m_rdata),  64'd0);
    check_eq("oor_rvalid", 64'(rf_if.m_rvalid), 64'd1);
    rvalid = 1'b1; raddr = 8'd50; step();
    idle(); repeat (LAT) step();

    // Reset pulsed between edges with reads in flight
    for (int i = 1; i <= 3; i++) begin
      rvalid = 1'b1; raddr = 8'(i); step();
    end
    idle();
    #1 reset = 1'b1;
    #1;
    check_eq("midrst_rf_rvalid", 64'(rf_if.m_rvalid), 64'd0);
    check_eq("midrst_wf_rvalid", 64'(wf_if.m_rvalid), 64'd0);
    #1 reset = 1'b0;
    model_clear();
    repeat (LAT + 1) step();
    rvalid = 1'b1; raddr = 8'd2; step();
    rvalid = 1'b1; raddr = 8'd1; step();
    idle(); repeat (LAT) step();

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      cke    = ($urandom_range(0, 9) != 0);
      wvalid = $urandom_range(0, 1) == 1;
      waddr  = 8'($urandom_range(0, 255));
      wdata  = $urandom;
      wstrb  = 4'($urandom);
      rvalid = $urandom_range(0, 2) != 0;
      raddr  = ($urandom_range(0, 3) == 0) ? waddr : 8'($urandom_range(0, 255));
      step();
    end
    idle(); repeat (LAT + 1) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
